// File: rtl/fetch_sequencer.sv
// Multicycle instruction-fetch / PC sequencer: FETCH -> WAIT -> EXEC, one instruction in flight.
// Define FETCH_PERF_CNT_EN to add the fetch_count / redirect_count performance counters.
module fetch_sequencer #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned IMM_W    = 6,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         op,
    output logic               instr_valid,
    input  logic               pcsrc,
    input  logic               jump,
    input  logic               stall,
    output logic [PC_W-1:0]    pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        redirect_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2
    } state_e;

    localparam int unsigned EXT_W = PC_W - IMM_W;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;

    logic [PC_W-1:0]    pc_plus1;
    logic [PC_W-1:0]    branch_off;
    logic [PC_W-1:0]    next_pc;
    logic               capture;
    logic               exec_exit;

    assign pc_plus1   = pc_q + PC_W'(1);
    assign branch_off = {{EXT_W{instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};
    assign capture    = (state_q == S_WAIT) && imem_rvalid;
    assign exec_exit  = (state_q == S_EXEC) && !stall;

    // Jump target takes priority over a taken branch.
    always_comb begin
        if (jump) begin
            next_pc = instr_q[PC_W-1:0];
        end else if (pcsrc) begin
            next_pc = pc_plus1 + branch_off;
        end else begin
            next_pc = pc_plus1;
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            S_FETCH: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            default: begin
                instr_valid_d = 1'b0;
                state_d       = S_FETCH;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= PC_W'(RESET_PC);
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Request is masked while reset is held so the reset cycle never issues a fetch.
    assign imem_req    = (state_q == S_FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[INSTR_W-1 -: 3];
    assign instr_valid = instr_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    always_comb begin
        fetch_count_d    = fetch_count_q + (capture ? 32'd1 : 32'd0);
        redirect_count_d = redirect_count_q + ((exec_exit && (jump || pcsrc)) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`else
    logic unused_perf;
    assign unused_perf = capture ^ exec_exit;
`endif

endmodule
